bus_src_arbiter: RTL
====================

# bus_src_arbiter

Sequential arbiter that selects which of up to 24 bus sources (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C) drives the shared CPU bus. It issues a registered one-hot 32-bit grant that feeds the 32-to-5 bus-select encoder, plus the matching 5-bit index. The grant is held for the owner while it requests, with bounded tenure and a one-cycle dead turnaround between owners. It sits between the control unit's per-source "out" strobes and the bus multiplexer select.

## Interface
- NREQ, 24: number of requesters, 1..24; bits NREQ..31 of grant_oh are always 0.
- MAX_HOLD, 8: cycles an unlocked owner may hold the bus while others wait, 1..255.
- clk  in  1  rising-edge clock.
- clr  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-source bus request, level-sensitive.
- lock  in  1  while high, the current owner cannot be preempted by tenure expiry.
- grant_oh  out  32  one-hot grant to the encoder; all-zero when idle or turning around.
- grant_idx  out  5  binary index of the owner; 5'd31 when no grant.
- busy  out  1  high while in GRANT.
- contend  out  1  high while the owner holds the bus and at least one other req is high.

## Operation
- States: IDLE, GRANT, TURN. Reset state is IDLE.
- Reset values: grant_oh=0, grant_idx=31, busy=0, contend=0, tenure counter=0, round-robin pointer=0.
- IDLE with any req high:
  - Pick the winner.
  - Load grant_oh/grant_idx.
  - Go to GRANT and clear the counter.
- IDLE with no req: stay in IDLE.
- GRANT:
  - Counter increments each cycle that contend=1, saturating at MAX_HOLD.
  - Owner's req drops: go to TURN.
  - Else lock=0 and counter==MAX_HOLD: go to TURN (preemption).
  - Else stay in GRANT.
- TURN:
  - Outputs show no grant for exactly one cycle.
  - Next cycle: return to IDLE-equivalent pick, i.e. a direct GRANT if any req is high, else IDLE.
- Winner selection:
  - Round-robin: search from pointer upward, wrapping at NREQ-1→0.
  - On every grant, pointer becomes winner+1, modulo NREQ.
- A preempted owner still requesting competes normally and is ranked last under round-robin.
- An owner with lock high keeps the bus indefinitely while its req stays high.
- lock is ignored outside GRANT.
- grant_oh always has at most one bit set. grant_idx always equals the encoding of grant_oh, or 31 when grant_oh is zero.

## Timing
- All outputs are registered with no combinational path from inputs.
- Grant latency from IDLE: req high before edge N → grant valid after edge N.
- Release: owner drops req before edge N → grant zero after edge N (TURN). The next owner is visible after edge N+1.
- Preemption: with contend high for MAX_HOLD consecutive owner cycles and lock low, the grant drops at the following edge.
- Simultaneous owner req drop and lock high: release wins.
- clr asserted mid-grant: outputs return to reset values immediately, asynchronously. The pointer resets to 0.

## Configuration
- BUS_ARB_RR_EN defined: round-robin selection with a rotating pointer, as above.
- BUS_ARB_RR_EN undefined:
  - Fixed priority; lowest index wins.
  - The pointer register is removed.
  - Tenure preemption is still active, so higher sources cannot starve a locked-out owner forever. Lower indices can still starve higher ones.

## Structure
- Shared package bus_arb_pkg holds:
  - The state enum (IDLE, GRANT, TURN).
  - NREQ_MAX=24.
  - Source index constants: SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23.
  - IDX_NONE=31.
- One sub-module, bus_arb_pick, is natural: combinational masked priority picker. Inputs are req and pointer; outputs are winner one-hot, winner index, and any.

## Test plan
- Reset: clr low with req=24'hFFFFFF → grant_oh=0, grant_idx=31, busy=0. Release clr, then 1 cycle → grant_oh=32'h1, grant_idx=0.
- Single request: req=SRC_PC bit only (24'h100000) → grant_oh=32'h00100000, idx=20. Drop req → one cycle of grant_oh=0, then IDLE.
- Round-robin (BUS_ARB_RR_EN): req bits 3, 5, 17 held, each owner drops req after 2 cycles → grant order 3, 5, 17, 3, with a one-cycle zero gap between each.
- Preemption: MAX_HOLD=4, req bits 1 and 2 held, lock=0 → owner 1 holds 4 cycles, TURN, then owner 2. Repeat with lock=1 → owner 1 holds indefinitely and contend=1 throughout.
- Fixed priority (macro undefined): req=24'h800001 → idx 0 first. After preemption, idx 0 regains the bus while still requesting, and idx 23 wins only when bit 0 is low.
- Asynchronous reset mid-grant: assert clr between edges while owner=21 → outputs go to reset values before the next edge, and the pointer restarts at 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the CPU bus source arbiter (bus_src_arbiter).
// Optional feature macro used by the arbiter: BUS_ARB_RR_EN.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int NREQ_MAX = 24;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  localparam logic [4:0] IDX_NONE = 5'd31;

  // Next round-robin start position after a grant to idx, wrapping at n.
  function automatic logic [4:0] wrap_inc(input logic [4:0] idx, input int n);
    return ((int'(idx) + 1) >= n) ? 5'd0 : idx + 5'd1;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational masked priority picker: first request at or above ptr_i,
// wrapping at NREQ-1 -> 0. A ptr_i of zero gives plain lowest-index priority.
module bus_arb_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = NREQ_MAX
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [4:0]      ptr_i,
  output logic [NREQ-1:0] win_oh_o,
  output logic [4:0]      win_idx_o,
  output logic            any_o
);

  logic [5:0]      pos;
  logic [NREQ-1:0] rot;

  // Scanning from the farthest offset down lets the nearest requester overwrite.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = IDX_NONE;
    any_o     = 1'b0;
    pos       = '0;
    rot       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + 6'(k);
      if (pos >= 6'(NREQ)) begin
        pos = pos - 6'(NREQ);
      end
      rot = req_i >> pos;
      if (rot[0]) begin
        any_o     = 1'b1;
        win_idx_o = pos[4:0];
        win_oh_o  = NREQ'(1'b1) << pos;
      end
    end
  end

endmodule

// File: rtl/bus_src_arbiter.sv
// Bus source arbiter: registered one-hot grant with bounded tenure and a dead
// turnaround cycle. Define BUS_ARB_RR_EN for round-robin, else fixed priority.
module bus_src_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 24,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  input  logic            lock,
  output logic [31:0]     grant_oh,
  output logic [4:0]      grant_idx,
  output logic            busy,
  output logic            contend
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;
  logic [31:0]     grant_oh_q, grant_oh_d;
  logic [4:0]      grant_idx_q, grant_idx_d;
  logic            busy_q, busy_d;
  logic            contend_q, contend_d;

  logic [4:0]      ptr;
  logic [NREQ-1:0] pick_oh;
  logic [4:0]      pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] own_mask;
  logic            own_req;
  logic            do_pick;

  bus_arb_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign own_mask = grant_oh_q[NREQ-1:0];
  assign own_req  = |(req & own_mask);

`ifdef BUS_ARB_RR_EN
  logic [4:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (do_pick && pick_any) begin
      ptr_d = wrap_inc(pick_idx, NREQ);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // TURN picks exactly like IDLE, so a waiting source is granted right after the gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    busy_d      = busy_q;
    contend_d   = contend_q;
    do_pick     = 1'b0;
    cnt_inc     = (contend_q && (cnt_q != HOLD_LIM)) ? cnt_q + 8'd1 : cnt_q;

    unique case (state_q)
      GRANT: begin
        if (!own_req || (!lock && (cnt_inc == HOLD_LIM))) begin
          state_d     = TURN;
          cnt_d       = '0;
          grant_oh_d  = '0;
          grant_idx_d = IDX_NONE;
          busy_d      = 1'b0;
          contend_d   = 1'b0;
        end else begin
          cnt_d     = cnt_inc;
          contend_d = |(req & ~own_mask);
        end
      end
      default: begin
        do_pick = 1'b1;
      end
    endcase

    if (do_pick) begin
      cnt_d = '0;
      if (pick_any) begin
        state_d     = GRANT;
        grant_oh_d  = 32'(pick_oh);
        grant_idx_d = pick_idx;
        busy_d      = 1'b1;
        contend_d   = |(req & ~pick_oh);
      end else begin
        state_d     = IDLE;
        grant_oh_d  = '0;
        grant_idx_d = IDX_NONE;
        busy_d      = 1'b0;
        contend_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= IDX_NONE;
      busy_q      <= 1'b0;
      contend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
      busy_q      <= busy_d;
      contend_q   <= contend_d;
    end
  end

  assign grant_oh  = grant_oh_q;
  assign grant_idx = grant_idx_q;
  assign busy      = busy_q;
  assign contend   = contend_q;

endmodule
